// File: rtl/regfile_dbg_arbiter_pkg.sv
// Shared definitions for the LC-3 register-file debug arbiter:
// FSM encoding, default widths and debug request-type constants.
package lc3_dbg_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PEND = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WR = 1'b1;

endpackage

// File: rtl/regfile_dbg_arbiter_if.sv
// Debug host request/response channel.
// The host drives through the master modport.
// The arbiter drives through the slave modport.
interface regfile_dbg_arbiter_if #(
    parameter int DATA_W = lc3_dbg_pkg::DATA_W_DEF,
    parameter int ADDR_W = lc3_dbg_pkg::ADDR_W_DEF
);
    logic              dbg_req_valid;
    logic              dbg_req_ready;
    logic              dbg_req_wr;
    logic [ADDR_W-1:0] dbg_req_addr;
    logic [DATA_W-1:0] dbg_req_wdata;
    logic              dbg_rsp_valid;
    logic              dbg_rsp_ready;
    logic [DATA_W-1:0] dbg_rsp_rdata;

    modport master (
        output dbg_req_valid, dbg_req_wr, dbg_req_addr, dbg_req_wdata, dbg_rsp_ready,
        input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata
    );

    modport slave (
        input  dbg_req_valid, dbg_req_wr, dbg_req_addr, dbg_req_wdata, dbg_rsp_ready,
        output dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata
    );
endinterface

// File: rtl/regfile_dbg_arbiter_port_mux.sv
// Combinational steering of the Regfile write port and SR1 select
// between the CPU and the debug request.
// During a forced slot, the CPU write is suppressed rather than merged.
module regfile_port_mux
    import lc3_dbg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              grant,
    input  logic              req_wr,
    input  logic              mask_cpu,
    input  logic              cpu_ld_reg,
    input  logic [ADDR_W-1:0] cpu_dr,
    input  logic [DATA_W-1:0] cpu_bus,
    input  logic [ADDR_W-1:0] cpu_sr1_sel,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              rf_ld_reg,
    output logic [ADDR_W-1:0] rf_dr,
    output logic [DATA_W-1:0] rf_bus,
    output logic [ADDR_W-1:0] rf_sr1_sel
);

    // Hand the write port or the SR1 select to debug while it holds the grant.
    always_comb begin
        rf_ld_reg  = cpu_ld_reg & ~mask_cpu;
        rf_dr      = cpu_dr;
        rf_bus     = cpu_bus;
        rf_sr1_sel = cpu_sr1_sel;
        if (grant && req_wr == REQ_WR) begin
            rf_ld_reg = 1'b1;
            rf_dr     = dbg_addr;
            rf_bus    = dbg_wdata;
        end else if (grant) begin
            rf_sr1_sel = dbg_addr;
        end
    end

endmodule

// File: rtl/regfile_dbg_arbiter.sv
// Arbitrates the LC-3 Regfile write port and SR1 read port.
// The CPU control unit has priority over the debug host.
// A starvation counter forces a one-cycle CPU stall,
// so a pending debug access always completes.
module regfile_dbg_arbiter
    import lc3_dbg_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_Clk,
    input  logic                  reset,
    input  logic                  cpu_ld_reg,
    input  logic [ADDR_W-1:0]     cpu_dr,
    input  logic [DATA_W-1:0]     cpu_bus,
    input  logic [ADDR_W-1:0]     cpu_sr1_sel,
    input  logic                  cpu_rd_active,
    output logic                  cpu_stall,
    regfile_dbg_arbiter_if.slave  dbg,
    output logic                  rf_ld_reg,
    output logic [ADDR_W-1:0]     rf_dr,
    output logic [DATA_W-1:0]     rf_bus,
    output logic [ADDR_W-1:0]     rf_sr1_sel,
    input  logic [DATA_W-1:0]     rf_sr1
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]        state;
    logic [3:0]        starve_cnt;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] rsp_rdata;
    logic              forced;
    logic              slot_free;
    logic              grant;

    // Decide whether this PEND cycle is a debug slot (free or forced).
    always_comb begin
        forced    = (state == PEND) && (starve_cnt == LIMIT);
        slot_free = (req_wr == REQ_WR) ? ~cpu_ld_reg : ~cpu_rd_active;
        grant     = (state == PEND) && (forced || slot_free);
    end

    assign cpu_stall         = forced;
    assign dbg.dbg_req_ready = (state == IDLE) && !reset;
    assign dbg.dbg_rsp_valid = (state == RESP);
    assign dbg.dbg_rsp_rdata = rsp_rdata;

    // Request capture, slot wait with saturating starvation count, and response hold.
    always_ff @(posedge i_Clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            req_wr     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            rsp_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dbg.dbg_req_valid && dbg.dbg_req_ready) begin
                        req_wr     <= dbg.dbg_req_wr;
                        req_addr   <= dbg.dbg_req_addr;
                        req_wdata  <= dbg.dbg_req_wdata;
                        starve_cnt <= '0;
                        state      <= PEND;
                    end
                end
                PEND: begin
                    if (grant) begin
                        rsp_rdata <= (req_wr == REQ_WR) ? req_wdata : rf_sr1;
                        state     <= RESP;
                    end else if (starve_cnt != LIMIT) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (dbg.dbg_rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    regfile_port_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_mux (
        .grant       (grant),
        .req_wr      (req_wr),
        .mask_cpu    (forced),
        .cpu_ld_reg  (cpu_ld_reg),
        .cpu_dr      (cpu_dr),
        .cpu_bus     (cpu_bus),
        .cpu_sr1_sel (cpu_sr1_sel),
        .dbg_addr    (req_addr),
        .dbg_wdata   (req_wdata),
        .rf_ld_reg   (rf_ld_reg),
        .rf_dr       (rf_dr),
        .rf_bus      (rf_bus),
        .rf_sr1_sel  (rf_sr1_sel)
    );

endmodule

// File: tb/tb_regfile_dbg_arbiter.sv
// Directed bench for regfile_dbg_arbiter.
// A small behavioural Regfile is attached to the rf_* port.
// Inputs change on the falling edge, and outputs are checked 1 time unit later.
module tb_regfile_dbg_arbiter;
    import lc3_dbg_pkg::*;

    logic        i_Clk;
    logic        reset;
    logic        rf_clear;
    logic        cpu_ld_reg;
    logic [2:0]  cpu_dr;
    logic [15:0] cpu_bus;
    logic [2:0]  cpu_sr1_sel;
    logic        cpu_rd_active;
    logic        cpu_stall;
    logic        rf_ld_reg;
    logic [2:0]  rf_dr;
    logic [15:0] rf_bus;
    logic [2:0]  rf_sr1_sel;
    logic [15:0] rf_sr1;
    logic [15:0] rf_model [8];

    int assert_count = 0;
    int fail_count   = 0;

    regfile_dbg_arbiter_if dbg_bus ();

    regfile_dbg_arbiter #(
        .DATA_W       (16),
        .ADDR_W       (3),
        .STARVE_LIMIT (4)
    ) dut (
        .i_Clk         (i_Clk),
        .reset         (reset),
        .cpu_ld_reg    (cpu_ld_reg),
        .cpu_dr        (cpu_dr),
        .cpu_bus       (cpu_bus),
        .cpu_sr1_sel   (cpu_sr1_sel),
        .cpu_rd_active (cpu_rd_active),
        .cpu_stall     (cpu_stall),
        .dbg           (dbg_bus),
        .rf_ld_reg     (rf_ld_reg),
        .rf_dr         (rf_dr),
        .rf_bus        (rf_bus),
        .rf_sr1_sel    (rf_sr1_sel),
        .rf_sr1        (rf_sr1)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Edge-written register file with combinational SR1 read.
    always @(posedge i_Clk or posedge rf_clear) begin
        if (rf_clear) begin
            for (int i = 0; i < 8; i++) rf_model[i] <= '0;
        end else if (rf_ld_reg) begin
            rf_model[rf_dr] <= rf_bus;
        end
    end
    assign rf_sr1 = rf_model[rf_sr1_sel];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic wr, input logic [2:0] addr,
                                 input logic [15:0] wdata, input logic rsp_ready);
        dbg_bus.dbg_req_valid = valid;
        dbg_bus.dbg_req_wr    = wr;
        dbg_bus.dbg_req_addr  = addr;
        dbg_bus.dbg_req_wdata = wdata;
        dbg_bus.dbg_rsp_ready = rsp_ready;
    endtask

    task automatic debugRead(input logic [2:0] addr, input logic [15:0] exp, input string tag);
        @(negedge i_Clk);
        applyStimulus(1'b1, REQ_RD, addr, 16'h0, 1'b0);
        #1 checkOutput({tag, "_req_ready"}, 32'(dbg_bus.dbg_req_ready), 1);
        @(negedge i_Clk);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b0);
        #1 checkOutput({tag, "_sr1_sel"}, 32'(rf_sr1_sel), 32'(addr));
        @(negedge i_Clk);
        #1 checkOutput({tag, "_rsp_valid"}, 32'(dbg_bus.dbg_rsp_valid), 1);
        checkOutput({tag, "_rdata"}, 32'(dbg_bus.dbg_rsp_rdata), 32'(exp));
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b1);
        @(negedge i_Clk);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b0);
        #1 checkOutput({tag, "_rsp_done"}, 32'(dbg_bus.dbg_rsp_valid), 0);
    endtask

    initial begin
        reset         = 1'b1;
        rf_clear      = 1'b1;
        cpu_ld_reg    = 1'b0;
        cpu_dr        = '0;
        cpu_bus       = '0;
        cpu_sr1_sel   = '0;
        cpu_rd_active = 1'b0;
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b0);

        // Reset state: handshakes idle, rf_* follow the CPU.
        @(negedge i_Clk);
        cpu_ld_reg = 1'b1; cpu_dr = 3'd6; cpu_bus = 16'h5555; cpu_sr1_sel = 3'd5;
        #1 checkOutput("rst_req_ready", 32'(dbg_bus.dbg_req_ready), 0);
        checkOutput("rst_rsp_valid", 32'(dbg_bus.dbg_rsp_valid), 0);
        checkOutput("rst_stall", 32'(cpu_stall), 0);
        checkOutput("rst_ld_pass", 32'(rf_ld_reg), 1);
        checkOutput("rst_dr_pass", 32'(rf_dr), 6);
        checkOutput("rst_bus_pass", 32'(rf_bus), 'h5555);
        checkOutput("rst_sr1_pass", 32'(rf_sr1_sel), 5);
        @(negedge i_Clk);
        cpu_ld_reg = 1'b0; cpu_dr = '0; cpu_bus = '0; cpu_sr1_sel = '0;
        reset = 1'b0; rf_clear = 1'b0;
        #1 checkOutput("post_rst_req_ready", 32'(dbg_bus.dbg_req_ready), 1);

        // Debug write R3=BEEF with the CPU idle.
        @(negedge i_Clk);
        applyStimulus(1'b1, REQ_WR, 3'd3, 16'hBEEF, 1'b0);
        @(negedge i_Clk);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b0);
        #1 checkOutput("wr3_req_ready", 32'(dbg_bus.dbg_req_ready), 0);
        checkOutput("wr3_ld", 32'(rf_ld_reg), 1);
        checkOutput("wr3_dr", 32'(rf_dr), 3);
        checkOutput("wr3_bus", 32'(rf_bus), 'hBEEF);
        checkOutput("wr3_stall", 32'(cpu_stall), 0);
        @(negedge i_Clk);
        #1 checkOutput("wr3_rsp_valid", 32'(dbg_bus.dbg_rsp_valid), 1);
        checkOutput("wr3_rdata", 32'(dbg_bus.dbg_rsp_rdata), 'hBEEF);
        checkOutput("wr3_resp_ld", 32'(rf_ld_reg), 0);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b1);
        @(negedge i_Clk);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b0);
        #1 checkOutput("wr3_idle_ready", 32'(dbg_bus.dbg_req_ready), 1);
        debugRead(3'd3, 16'hBEEF, "rd3");

        // Starvation: the CPU writes R1 every cycle, and the debug write of R5 is forced in the 5th PEND cycle.
        @(negedge i_Clk);
        cpu_ld_reg = 1'b1; cpu_dr = 3'd1; cpu_bus = 16'h7777;
        applyStimulus(1'b1, REQ_WR, 3'd5, 16'h1234, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge i_Clk);
            applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b0);
            #1;
            if (c < 5) begin
                checkOutput("starve_stall_off", 32'(cpu_stall), 0);
                checkOutput("starve_dr_cpu", 32'(rf_dr), 1);
            end else begin
                checkOutput("starve_stall_on", 32'(cpu_stall), 1);
                checkOutput("starve_ld", 32'(rf_ld_reg), 1);
                checkOutput("starve_dr_dbg", 32'(rf_dr), 5);
                checkOutput("starve_bus_dbg", 32'(rf_bus), 'h1234);
            end
        end
        @(negedge i_Clk);
        #1 checkOutput("starve_resp_stall", 32'(cpu_stall), 0);
        checkOutput("starve_rsp_valid", 32'(dbg_bus.dbg_rsp_valid), 1);
        checkOutput("starve_rdata", 32'(dbg_bus.dbg_rsp_rdata), 'h1234);
        checkOutput("starve_dr_back", 32'(rf_dr), 1);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b1);
        @(negedge i_Clk);
        cpu_ld_reg = 1'b0; cpu_dr = '0; cpu_bus = '0;
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b0);
        #1 checkOutput("starve_r5", 32'(rf_model[5]), 'h1234);
        checkOutput("starve_r1", 32'(rf_model[1]), 'h7777);

        // Debug read R0, with the CPU reading for the first two PEND cycles.
        @(negedge i_Clk);
        cpu_rd_active = 1'b1; cpu_sr1_sel = 3'd7;
        applyStimulus(1'b1, REQ_RD, 3'd0, 16'h0, 1'b0);
        @(negedge i_Clk);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b0);
        #1 checkOutput("rd0_blk1_sel", 32'(rf_sr1_sel), 7);
        @(negedge i_Clk);
        #1 checkOutput("rd0_blk2_sel", 32'(rf_sr1_sel), 7);
        @(negedge i_Clk);
        cpu_rd_active = 1'b0;
        #1 checkOutput("rd0_slot_sel", 32'(rf_sr1_sel), 0);
        checkOutput("rd0_slot_stall", 32'(cpu_stall), 0);
        @(negedge i_Clk);
        #1 checkOutput("rd0_rsp_valid", 32'(dbg_bus.dbg_rsp_valid), 1);
        checkOutput("rd0_rdata", 32'(dbg_bus.dbg_rsp_rdata), 'h0000);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b1);
        @(negedge i_Clk);
        cpu_sr1_sel = '0;
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b0);

        // Response backpressure on a read of R1.
        @(negedge i_Clk);
        applyStimulus(1'b1, REQ_RD, 3'd1, 16'h0, 1'b0);
        @(negedge i_Clk);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge i_Clk);
            #1 checkOutput("bp_rsp_valid", 32'(dbg_bus.dbg_rsp_valid), 1);
            checkOutput("bp_rdata", 32'(dbg_bus.dbg_rsp_rdata), 'h7777);
            checkOutput("bp_req_ready", 32'(dbg_bus.dbg_req_ready), 0);
        end
        @(negedge i_Clk);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b1);
        #1 checkOutput("bp_hs_valid", 32'(dbg_bus.dbg_rsp_valid), 1);
        checkOutput("bp_hs_req_ready", 32'(dbg_bus.dbg_req_ready), 0);
        @(negedge i_Clk);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b0);
        #1 checkOutput("bp_idle_valid", 32'(dbg_bus.dbg_rsp_valid), 0);
        checkOutput("bp_idle_ready", 32'(dbg_bus.dbg_req_ready), 1);

        // Same-cycle hazard: the CPU writes R2 during the debug read slot of R2.
        @(negedge i_Clk);
        applyStimulus(1'b1, REQ_RD, 3'd2, 16'h0, 1'b0);
        @(negedge i_Clk);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b0);
        cpu_ld_reg = 1'b1; cpu_dr = 3'd2; cpu_bus = 16'h00AA;
        #1 checkOutput("hz_cpu_ld", 32'(rf_ld_reg), 1);
        checkOutput("hz_cpu_dr", 32'(rf_dr), 2);
        checkOutput("hz_sel", 32'(rf_sr1_sel), 2);
        checkOutput("hz_stall", 32'(cpu_stall), 0);
        @(negedge i_Clk);
        cpu_ld_reg = 1'b0; cpu_dr = '0; cpu_bus = '0;
        #1 checkOutput("hz_old_rdata", 32'(dbg_bus.dbg_rsp_rdata), 'h0000);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b1);
        @(negedge i_Clk);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b0);
        debugRead(3'd2, 16'h00AA, "hz_new");

        // Reset during PEND: the blocked write of R6 is dropped.
        @(negedge i_Clk);
        cpu_ld_reg = 1'b1; cpu_dr = 3'd4; cpu_bus = 16'h1111;
        applyStimulus(1'b1, REQ_WR, 3'd6, 16'hDEAD, 1'b0);
        @(negedge i_Clk);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b0);
        #1 checkOutput("rp_blocked_stall", 32'(cpu_stall), 0);
        #1 reset = 1'b1;
        #1 checkOutput("rp_req_ready", 32'(dbg_bus.dbg_req_ready), 0);
        checkOutput("rp_rsp_valid", 32'(dbg_bus.dbg_rsp_valid), 0);
        checkOutput("rp_stall", 32'(cpu_stall), 0);
        checkOutput("rp_dr_pass", 32'(rf_dr), 4);
        @(negedge i_Clk);
        cpu_ld_reg = 1'b0; cpu_dr = '0; cpu_bus = '0;
        repeat (5) @(negedge i_Clk);
        reset = 1'b0;
        #1 checkOutput("rp_post_ready", 32'(dbg_bus.dbg_req_ready), 1);
        checkOutput("rp_r6_unwritten", 32'(rf_model[6]), 'h0000);
        for (int c = 0; c < 6; c++) begin
            @(negedge i_Clk);
            #1 checkOutput("rp_quiet_ld", 32'(rf_ld_reg), 0);
            checkOutput("rp_quiet_valid", 32'(dbg_bus.dbg_rsp_valid), 0);
        end
        checkOutput("rp_r6_final", 32'(rf_model[6]), 'h0000);

        // Reset during RESP: the pending response is dropped.
        @(negedge i_Clk);
        applyStimulus(1'b1, REQ_RD, 3'd3, 16'h0, 1'b0);
        @(negedge i_Clk);
        applyStimulus(1'b0, REQ_RD, 3'd0, 16'h0, 1'b0);
        @(negedge i_Clk);
        #1 checkOutput("rr_rsp_valid_pre", 32'(dbg_bus.dbg_rsp_valid), 1);
        #1 reset = 1'b1;
        #1 checkOutput("rr_rsp_valid", 32'(dbg_bus.dbg_rsp_valid), 0);
        checkOutput("rr_req_ready", 32'(dbg_bus.dbg_req_ready), 0);
        @(negedge i_Clk);
        reset = 1'b0;
        #1 checkOutput("rr_post_ready", 32'(dbg_bus.dbg_req_ready), 1);
        checkOutput("rr_post_valid", 32'(dbg_bus.dbg_rsp_valid), 0);
        @(negedge i_Clk);
        #1 checkOutput("rr_idle_valid", 32'(dbg_bus.dbg_rsp_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
